br_resolve_unit: RTL

Pipelined branch-resolution unit for the execute stage, downstream of the ALU comparison path. Accepts a conditional-branch request (two register operands, branch op, PC, immediate) over a valid/ready handshake. Evaluates the signed or unsigned condition, computes taken target and fall-through PC, and presents a registered redirect decision to the fetch/PC logic two cycles later. Sustains one branch per cycle under backpressure and supports pipeline flush.

---
 rtl/br_pkg.sv | 28 ++
 rtl/br_cmp_core.sv | 35 +++
 rtl/br_resolve_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/br_pkg.sv
// Shared definitions for the branch-resolution unit: op encodings and the S2 result record.
package br_pkg;

  localparam int unsigned BR_PC_W = 32;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // Unused funct3 slots in the branch opcode space
  localparam logic [2:0] BR_ILL0 = 3'b010;
  localparam logic [2:0] BR_ILL1 = 3'b011;

  typedef struct packed {
    logic               taken;
    logic               illegal;
    logic               misalign;
    logic [BR_PC_W-1:0] next_pc;
  } br_result_t;

  function automatic logic br_is_illegal(input logic [2:0] op);
    return (op == BR_ILL0) || (op == BR_ILL1);
  endfunction

endpackage

// File: rtl/br_cmp_core.sv
// Combinational branch condition evaluator: signed/unsigned compare selected by funct3.
module br_cmp_core
  import br_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic        cond_true,
  output logic        illegal
);

  logic eq;
  logic lt;
  logic ltu;

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

  always_comb begin
    cond_true = 1'b0;
    case (op)
      BR_BEQ:  cond_true = eq;
      BR_BNE:  cond_true = !eq;
      BR_BLT:  cond_true = lt;
      BR_BGE:  cond_true = !lt;
      BR_BLTU: cond_true = ltu;
      BR_BGEU: cond_true = !ltu;
      default: cond_true = 1'b0;
    endcase
  end

  assign illegal = br_is_illegal(op);

endmodule

// File: rtl/br_resolve_unit.sv
// Two-stage branch resolution unit (S1 input register, S2 result register) with valid/ready and flush.
// Optional feature macro: BR_MISALIGN_CHECK_EN enables the taken-target alignment flag.
module br_resolve_unit
  import br_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [31:0]       in_a,
  input  logic [31:0]       in_b,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] in_imm,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_taken,
  output logic [ADDR_W-1:0] out_next_pc,
  output logic              out_illegal,
  output logic              out_misalign
);

  logic              s1_valid;
  logic [2:0]        s1_op;
  logic [31:0]       s1_a;
  logic [31:0]       s1_b;
  logic [ADDR_W-1:0] s1_pc;
  logic [ADDR_W-1:0] s1_imm;

  br_result_t        s2_q;
  br_result_t        res_d;

  logic              s2_free;
  logic              s1_free;
  logic              cond_true;
  logic              illegal;
  logic              taken;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] fall_pc;

  assign s2_free  = !out_valid || out_ready;
  assign s1_free  = !s1_valid || s2_free;
  assign in_ready = s1_free;

  br_cmp_core u_cmp (
    .a         (s1_a),
    .b         (s1_b),
    .op        (s1_op),
    .cond_true (cond_true),
    .illegal   (illegal)
  );

  always_comb begin
    target        = s1_pc + s1_imm;
    fall_pc       = s1_pc + ADDR_W'(4);
    taken         = cond_true && !illegal;
    res_d         = '0;
    res_d.taken   = taken;
    res_d.illegal = illegal;
    res_d.next_pc = BR_PC_W'(taken ? target : fall_pc);
`ifdef BR_MISALIGN_CHECK_EN
    res_d.misalign = taken && (target[1:0] != 2'b00);
`else
    res_d.misalign = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_pc     <= '0;
      s1_imm    <= '0;
      out_valid <= 1'b0;
      s2_q      <= '0;
    end else if (flush) begin
      // Flush wins over any capture or advance in the same cycle
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s1_free) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op  <= in_op;
          s1_a   <= in_a;
          s1_b   <= in_b;
          s1_pc  <= in_pc;
          s1_imm <= in_imm;
        end
      end
      if (s2_free) begin
        out_valid <= s1_valid;
        if (s1_valid) s2_q <= res_d;
      end
    end
  end

  assign out_taken    = s2_q.taken;
  assign out_illegal  = s2_q.illegal;
  assign out_misalign = s2_q.misalign;
  assign out_next_pc  = ADDR_W'(s2_q.next_pc);

endmodule
